// File: rtl/cpu7_excp_seq_pkg.sv
// Shared definitions for the exception/ERTN sequencer: datapath widths,
// CSR addresses and field positions, and the sequencer state encoding.
package cpu7_excp_seq_pkg;

    localparam int GRLEN   = 32;
    localparam int CSR_BIT = 14;

    // CSR addresses used by the sequencer
    localparam logic [CSR_BIT-1:0] CSR_CRMD  = 14'h000;
    localparam logic [CSR_BIT-1:0] CSR_PRMD  = 14'h001;
    localparam logic [CSR_BIT-1:0] CSR_EPC   = 14'h006;
    localparam logic [CSR_BIT-1:0] CSR_EBASE = 14'h00c;

    // CRMD / PRMD field positions
    localparam int CRMD_IE      = 2;
    localparam int PRMD_PIE     = 2;
    localparam int PRMD_PPLV_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_EXC_ERA    = 3'd1,
        ST_EXC_CRMD   = 3'd2,
        ST_EXC_REDIR  = 3'd3,
        ST_ERTN_PRMD  = 3'd4,
        ST_ERTN_CRMD  = 3'd5,
        ST_ERTN_REDIR = 3'd6
    } excp_state_t;

    // CRMD value restored by ERTN: IE <- PIE, PLV <- PPLV, all else zero
    function automatic logic [GRLEN-1:0] ertn_crmd(input logic pie, input logic [1:0] pplv);
        logic [GRLEN-1:0] v;
        v = '0;
        v[CRMD_IE] = pie;
        v[1:0]     = pplv;
        return v;
    endfunction

endpackage

// File: rtl/cpu7_excp_seq.sv
// Exception / ERTN sequencer. Owns the CSR write port and CSR read address,
// steps through the multi-cycle CSR updates of exception entry and ERTN,
// issues the fetch redirect and stalls pipeline CSR writes while busy.
// Optional feature macro: CPU7_EXCP_INT_EN (external interrupt input plus
// a shadow copy of CRMD.IE used to qualify it).
module cpu7_excp_seq
    import cpu7_excp_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ecl_exc_req,
    input  logic               ecl_ertn_req,
    input  logic [GRLEN-1:0]   ecl_pc,
    output logic               ecl_req_ack,
`ifdef CPU7_EXCP_INT_EN
    input  logic               int_req,
`endif
    input  logic               pipe_csr_wen,
    input  logic [CSR_BIT-1:0] pipe_csr_waddr,
    input  logic [GRLEN-1:0]   pipe_csr_wdata,
    input  logic [CSR_BIT-1:0] pipe_csr_raddr,
    output logic               pipe_csr_stall,
    output logic               csr_wen,
    output logic [CSR_BIT-1:0] csr_waddr,
    output logic [GRLEN-1:0]   csr_wdata,
    output logic [CSR_BIT-1:0] csr_raddr,
    input  logic [GRLEN-1:0]   csr_rdata,
    output logic               ecl_csr_except,
    output logic               redirect_vld,
    output logic [GRLEN-1:0]   redirect_pc,
    output logic               busy
);

    excp_state_t      state_q;
    excp_state_t      state_d;
    logic [GRLEN-1:0] epc_q;
    logic             pie_q;
    logic [1:0]       pplv_q;
    logic             is_idle;
    logic             take_int;
    logic             take_exc;
    logic             take_ertn;
    logic             accept;

`ifdef CPU7_EXCP_INT_EN
    logic             shadow_ie_q;
    assign take_int = int_req && shadow_ie_q && !ecl_exc_req;
`else
    assign take_int = 1'b0;
`endif

    // Request arbitration in IDLE: exception > interrupt > ERTN > pipeline write
    always_comb begin
        is_idle   = (state_q == ST_IDLE);
        take_exc  = is_idle && (ecl_exc_req || take_int);
        take_ertn = is_idle && !take_exc && ecl_ertn_req;
        accept    = take_exc || take_ertn;
    end

    // Next state and CSR port / redirect decode for the current state
    always_comb begin
        state_d        = state_q;
        csr_wen        = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        csr_raddr      = '0;
        ecl_csr_except = 1'b0;
        redirect_vld   = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            ST_IDLE: begin
                if (take_exc) begin
                    state_d = ST_EXC_ERA;
                end else if (take_ertn) begin
                    state_d = ST_ERTN_PRMD;
                end else begin
                    csr_wen   = pipe_csr_wen;
                    csr_waddr = pipe_csr_waddr;
                    csr_wdata = pipe_csr_wdata;
                    csr_raddr = pipe_csr_raddr;
                end
            end
            ST_EXC_ERA: begin
                csr_wen        = 1'b1;
                csr_waddr      = CSR_EPC;
                csr_wdata      = epc_q;
                ecl_csr_except = 1'b1;
                state_d        = ST_EXC_CRMD;
            end
            ST_EXC_CRMD: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_CRMD;
                csr_wdata = '0;
                state_d   = ST_EXC_REDIR;
            end
            ST_EXC_REDIR: begin
                csr_raddr    = CSR_EBASE;
                redirect_vld = 1'b1;
                redirect_pc  = csr_rdata;
                state_d      = ST_IDLE;
            end
            ST_ERTN_PRMD: begin
                csr_raddr = CSR_PRMD;
                state_d   = ST_ERTN_CRMD;
            end
            ST_ERTN_CRMD: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_CRMD;
                csr_wdata = ertn_crmd(pie_q, pplv_q);
                state_d   = ST_ERTN_REDIR;
            end
            ST_ERTN_REDIR: begin
                csr_raddr    = CSR_EPC;
                redirect_vld = 1'b1;
                redirect_pc  = csr_rdata;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and stall outputs
    always_comb begin
        ecl_req_ack    = accept;
        busy           = !is_idle;
        pipe_csr_stall = pipe_csr_wen && (!is_idle || accept);
    end

    // Sequencer state plus the values it carries between steps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            epc_q       <= '0;
            pie_q       <= 1'b0;
            pplv_q      <= 2'b00;
`ifdef CPU7_EXCP_INT_EN
            shadow_ie_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                epc_q <= ecl_pc;
            end
            if (state_q == ST_ERTN_PRMD) begin
                pie_q  <= csr_rdata[PRMD_PIE];
                pplv_q <= csr_rdata[PRMD_PPLV_LO +: 2];
            end
`ifdef CPU7_EXCP_INT_EN
            if (csr_wen && (csr_waddr == CSR_CRMD)) begin
                shadow_ie_q <= csr_wdata[CRMD_IE];
            end
`endif
        end
    end

endmodule

// File: tb/tb_cpu7_excp_seq.sv
// Testbench for cpu7_excp_seq: directed stimulus, expected events queued
// per cycle and checked by an independent monitor on the falling edge.
module tb_cpu7_excp_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ecl_exc_req;
    logic        ecl_ertn_req;
    logic [31:0] ecl_pc;
    logic        ecl_req_ack;
    logic        int_req;
    logic        pipe_csr_wen;
    logic [13:0] pipe_csr_waddr;
    logic [31:0] pipe_csr_wdata;
    logic [13:0] pipe_csr_raddr;
    logic        pipe_csr_stall;
    logic        csr_wen;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        ecl_csr_except;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    cpu7_excp_seq dut (
        .clk            (clk),
        .reset          (reset),
        .ecl_exc_req    (ecl_exc_req),
        .ecl_ertn_req   (ecl_ertn_req),
        .ecl_pc         (ecl_pc),
        .ecl_req_ack    (ecl_req_ack),
`ifdef CPU7_EXCP_INT_EN
        .int_req        (int_req),
`endif
        .pipe_csr_wen   (pipe_csr_wen),
        .pipe_csr_waddr (pipe_csr_waddr),
        .pipe_csr_wdata (pipe_csr_wdata),
        .pipe_csr_raddr (pipe_csr_raddr),
        .pipe_csr_stall (pipe_csr_stall),
        .csr_wen        (csr_wen),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata),
        .ecl_csr_except (ecl_csr_except),
        .redirect_vld   (redirect_vld),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    // Minimal CSR file: 16 registers indexed by the low address bits
    logic [31:0] csr_mem [16];
    initial for (int i = 0; i < 16; i++) csr_mem[i] = 32'h0;
    always @(posedge clk) if (csr_wen) csr_mem[csr_waddr[3:0]] <= csr_wdata;
    assign csr_rdata = csr_mem[csr_raddr[3:0]];

    typedef struct packed {
        logic        ack;
        logic        wen;
        logic [13:0] waddr;
        logic [31:0] wdata;
        logic        except;
        logic        rvld;
        logic [31:0] rpc;
        logic        stall;
        logic        busy;
    } ev_t;

    ev_t   exp_q[$];
    string tag_q[$];

    function automatic ev_t ev(input logic a, input logic w, input logic [13:0] wa,
                               input logic [31:0] wd, input logic ex, input logic rv,
                               input logic [31:0] rp, input logic st, input logic b);
        ev_t e;
        e.ack = a; e.wen = w; e.waddr = wa; e.wdata = wd; e.except = ex;
        e.rvld = rv; e.rpc = rp; e.stall = st; e.busy = b;
        return e;
    endfunction

    task automatic push(input string tag, input ev_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Monitor: every cycle the DUT shows activity, pop and compare
    always @(negedge clk) begin
        ev_t   obs;
        ev_t   e;
        string t;
        if (!reset) begin
            obs = ev(ecl_req_ack, csr_wen, csr_waddr, csr_wdata, ecl_csr_except,
                     redirect_vld, redirect_pc, pipe_csr_stall, busy);
            if (obs.ack | obs.wen | obs.except | obs.rvld | obs.stall | obs.busy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got %h want none", obs);
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    if (obs !== e) begin
                        fails++;
                        $display("FAIL %s: got %h want %h", t, obs, e);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; ecl_exc_req = 0; ecl_ertn_req = 0; ecl_pc = 0; int_req = 0;
        pipe_csr_wen = 0; pipe_csr_waddr = 0; pipe_csr_wdata = 0; pipe_csr_raddr = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_wen", {31'b0, csr_wen}, 32'h0);
        chk("rst_redir", {31'b0, redirect_vld}, 32'h0);
        chk("rst_ack", {31'b0, ecl_req_ack}, 32'h0);
        chk("rst_except", {31'b0, ecl_csr_except}, 32'h0);
        reset = 1'b0;

        // Program EENTRY through the pipeline pass-through
        cyc(); pipe_csr_wen = 1; pipe_csr_waddr = 14'h00c; pipe_csr_wdata = 32'h1c000100;
        push("pipe_eentry", ev(0, 1, 14'h00c, 32'h1c000100, 0, 0, 0, 0, 0));

        // Exception entry
        cyc(); pipe_csr_wen = 0; ecl_exc_req = 1; ecl_pc = 32'h1c000040;
        push("exc_ack", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); ecl_exc_req = 0;
        push("exc_era", ev(0, 1, 14'h006, 32'h1c000040, 1, 0, 0, 0, 1));
        cyc(); push("exc_crmd", ev(0, 1, 14'h000, 32'h0, 0, 0, 0, 0, 1));
        cyc(); push("exc_redir", ev(0, 0, 0, 0, 0, 1, 32'h1c000100, 0, 1));
        cyc();

        // ERTN with PRMD={pie=1,pplv=3}, ERA=0x1c000044
        cyc(); pipe_csr_wen = 1; pipe_csr_waddr = 14'h001; pipe_csr_wdata = 32'h7;
        push("pipe_prmd", ev(0, 1, 14'h001, 32'h7, 0, 0, 0, 0, 0));
        cyc(); pipe_csr_waddr = 14'h006; pipe_csr_wdata = 32'h1c000044;
        push("pipe_era", ev(0, 1, 14'h006, 32'h1c000044, 0, 0, 0, 0, 0));
        cyc(); pipe_csr_wen = 0; ecl_ertn_req = 1; ecl_pc = 32'h1c000050;
        push("ertn_ack", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); ecl_ertn_req = 0;
        push("ertn_prmd", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(); push("ertn_crmd", ev(0, 1, 14'h000, 32'h7, 0, 0, 0, 0, 1));
        cyc(); push("ertn_redir", ev(0, 0, 0, 0, 0, 1, 32'h1c000044, 0, 1));
        cyc();

        // Pipeline CRMD write collides with an exception
        cyc(); pipe_csr_wen = 1; pipe_csr_waddr = 14'h000; pipe_csr_wdata = 32'h4;
        ecl_exc_req = 1; ecl_pc = 32'h1c000080;
        push("col_ack", ev(1, 0, 0, 0, 0, 0, 0, 1, 0));
        cyc(); ecl_exc_req = 0;
        push("col_era", ev(0, 1, 14'h006, 32'h1c000080, 1, 0, 0, 1, 1));
        cyc(); push("col_crmd", ev(0, 1, 14'h000, 32'h0, 0, 0, 0, 1, 1));
        cyc(); push("col_redir", ev(0, 0, 0, 0, 0, 1, 32'h1c000100, 1, 1));
        cyc(); push("col_pipe_lands", ev(0, 1, 14'h000, 32'h4, 0, 0, 0, 0, 0));
        cyc(); pipe_csr_wen = 0;

        // Exception and ERTN together: exception first, ERTN after its redirect
        cyc(); ecl_exc_req = 1; ecl_ertn_req = 1; ecl_pc = 32'h1c0000c0;
        push("both_exc_ack", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); ecl_exc_req = 0;
        push("both_era", ev(0, 1, 14'h006, 32'h1c0000c0, 1, 0, 0, 0, 1));
        cyc(); push("both_crmd", ev(0, 1, 14'h000, 32'h0, 0, 0, 0, 0, 1));
        cyc(); push("both_redir", ev(0, 0, 0, 0, 0, 1, 32'h1c000100, 0, 1));
        cyc(); push("both_ertn_ack", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); ecl_ertn_req = 0;
        push("both_ertn_prmd", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(); push("both_ertn_crmd", ev(0, 1, 14'h000, 32'h7, 0, 0, 0, 0, 1));
        cyc(); push("both_ertn_redir", ev(0, 0, 0, 0, 0, 1, 32'h1c0000c0, 0, 1));
        cyc();

        // Reset while in ERTN_CRMD aborts the sequence
        cyc(); ecl_ertn_req = 1;
        push("abort_ack", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); ecl_ertn_req = 0;
        push("abort_prmd", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(); reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_wen", {31'b0, csr_wen}, 32'h0);
        chk("abort_redir", {31'b0, redirect_vld}, 32'h0);
        cyc(); reset = 1'b0;
        cyc();
        cyc();

`ifdef CPU7_EXCP_INT_EN
        // Interrupt taken once IE is set; not re-taken after CRMD is cleared
        cyc(); pipe_csr_wen = 1; pipe_csr_waddr = 14'h000; pipe_csr_wdata = 32'h4;
        push("int_pipe_crmd", ev(0, 1, 14'h000, 32'h4, 0, 0, 0, 0, 0));
        cyc(); pipe_csr_wen = 0; int_req = 1; ecl_pc = 32'h1c000200;
        push("int_ack", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); push("int_era", ev(0, 1, 14'h006, 32'h1c000200, 1, 0, 0, 0, 1));
        cyc(); push("int_crmd", ev(0, 1, 14'h000, 32'h0, 0, 0, 0, 0, 1));
        cyc(); push("int_redir", ev(0, 0, 0, 0, 0, 1, 32'h1c000100, 0, 1));
        repeat (4) cyc();
        int_req = 0;
`endif

        repeat (3) cyc();
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
